split_slave_port: RTL and testbench

SPLIT_SLAVE_PORT -- requirements
Module: split_slave_port

---
 rtl/split_bus_pkg.sv | 17 +
 rtl/split_slave_port_if.sv | 24 ++
 rtl/split_slave_mem.sv | 38 +++
 rtl/split_slave_port.sv | 204 ++++++++++++++++++++
 tb/tb_split_slave_port.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/split_bus_pkg.sv
// rtl/split_bus_pkg.sv - shared FSM state encoding and mode constants for the split slave port
package split_bus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_ADDR       = 3'd1,
        ST_WDATA      = 3'd2,
        ST_WRITE      = 3'd3,
        ST_SPLIT      = 3'd4,
        ST_GRANT_WAIT = 3'd5,
        ST_RDATA      = 3'd6
    } split_state_t;

    localparam logic MODE_READ  = 1'b0;
    localparam logic MODE_WRITE = 1'b1;

endpackage

// File: rtl/split_slave_port_if.sv
// rtl/split_slave_port_if.sv - serial split-bus signals between master/arbiter and slave port
// Master side drives: ssel, mvalid, mmode, mwdata, split_grant.
// Slave side drives:  srdata, srvalid, sready, ssplit.
interface split_slave_port_if;
    logic ssel;
    logic mvalid;
    logic mmode;
    logic mwdata;
    logic split_grant;
    logic srdata;
    logic srvalid;
    logic sready;
    logic ssplit;

    modport master (
        output ssel, mvalid, mmode, mwdata, split_grant,
        input  srdata, srvalid, sready, ssplit
    );

    modport slave (
        input  ssel, mvalid, mmode, mwdata, split_grant,
        output srdata, srvalid, sready, ssplit
    );
endinterface

// File: rtl/split_slave_mem.sv
// rtl/split_slave_mem.sv - simple dual-address block RAM with pipelined read latency
// Ports: clk; we_i/waddr_i/wdata_i synchronous write; re_i/raddr_i read strobe;
//        rdata_o valid READ_LATENCY cycles after the strobe cycle.
module split_slave_mem #(
    parameter int DATA_WIDTH   = 8,
    parameter int MEM_DEPTH    = 2048,
    parameter int READ_LATENCY = 4,
    parameter int IDX_WIDTH    = 11
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic [IDX_WIDTH-1:0]  waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic                  re_i,
    input  logic [IDX_WIDTH-1:0]  raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q  [MEM_DEPTH];
    logic [DATA_WIDTH-1:0] pipe_q [READ_LATENCY];

    // No reset on the array or the read pipe so the block maps onto RAM primitives;
    // stage 0 is the RAM output register, the rest is a plain delay line.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            pipe_q[0] <= mem_q[raddr_i];
        end
        for (int i = 1; i < READ_LATENCY; i++) begin
            pipe_q[i] <= pipe_q[i-1];
        end
    end

    assign rdata_o = pipe_q[READ_LATENCY-1];

endmodule

// File: rtl/split_slave_port.sv
// rtl/split_slave_port.sv - serial bus slave with split-transaction reads over a local memory
// Ports: clk, rstn (async active-low); bus (slave modport): ssel/mvalid/mmode/mwdata serial
//        request, split_grant resume pulse, srdata/srvalid serial read data, sready, ssplit.
module split_slave_port
    import split_bus_pkg::*;
#(
    parameter int ADDR_WIDTH   = 12,
    parameter int DATA_WIDTH   = 8,
    parameter int MEM_DEPTH    = 2048,
    parameter int READ_LATENCY = 4
) (
    input  logic               clk,
    input  logic               rstn,
    split_slave_port_if.slave  bus
);

    localparam int MAX_W = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
    localparam int CW    = $clog2(MAX_W + 1);
    localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    split_state_t          state_q;
    logic                  mode_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic [DATA_WIDTH-1:0] rword_q;
    logic [CW-1:0]         cnt_q;
    logic [3:0]            lat_q;
    logic                  sready_q;
    logic                  ssplit_q;
    logic                  srvalid_q;
    logic                  srdata_q;

    logic                  bit_ok;
    logic [ADDR_WIDTH-1:0] addr_d;
    logic [DATA_WIDTH-1:0] data_d;
    logic                  addr_last;
    logic                  data_last;
    logic                  lat_done;
    logic                  mem_we;
    logic                  mem_re;
    logic [IDX_W-1:0]      mem_waddr;
    logic [IDX_W-1:0]      mem_raddr;
    logic [DATA_WIDTH-1:0] mem_rdata;

    function automatic logic [IDX_W-1:0] word_index(input logic [ADDR_WIDTH-1:0] a);
        return IDX_W'(32'(a) % 32'(MEM_DEPTH));
    endfunction

    assign bit_ok = bus.ssel & bus.mvalid;
    // LSB-first serial shift: after ADDR_WIDTH shifts bit 0 sits at position 0.
    assign addr_d = {bus.mwdata, addr_q[ADDR_WIDTH-1:1]};
    assign data_d = {bus.mwdata, data_q[DATA_WIDTH-1:1]};

    // Bit 0 of the address is taken in IDLE, so ADDR only counts the remaining bits.
    assign addr_last = (cnt_q == CW'(ADDR_WIDTH - 2));
    assign data_last = (cnt_q == CW'(DATA_WIDTH - 1));
    assign lat_done  = (lat_q == 4'(READ_LATENCY - 1));

    // The read strobe fires on the edge that enters SPLIT, using the address including
    // the bit being sampled, so the word arrives in the last SPLIT cycle.
    assign mem_re    = (state_q == ST_ADDR) && bit_ok && addr_last && (mode_q == MODE_READ);
    assign mem_raddr = word_index(addr_d);
    assign mem_we    = (state_q == ST_WRITE);
    assign mem_waddr = word_index(addr_q);

    split_slave_mem #(
        .DATA_WIDTH   (DATA_WIDTH),
        .MEM_DEPTH    (MEM_DEPTH),
        .READ_LATENCY (READ_LATENCY),
        .IDX_WIDTH    (IDX_W)
    ) u_mem (
        .clk     (clk),
        .we_i    (mem_we),
        .waddr_i (mem_waddr),
        .wdata_i (data_q),
        .re_i    (mem_re),
        .raddr_i (mem_raddr),
        .rdata_o (mem_rdata)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= ST_IDLE;
            mode_q    <= MODE_READ;
            addr_q    <= '0;
            data_q    <= '0;
            rword_q   <= '0;
            cnt_q     <= '0;
            lat_q     <= '0;
            sready_q  <= 1'b1;
            ssplit_q  <= 1'b0;
            srvalid_q <= 1'b0;
            srdata_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bit_ok) begin
                        mode_q   <= bus.mmode;
                        addr_q   <= addr_d;
                        cnt_q    <= '0;
                        sready_q <= 1'b0;
                        state_q  <= ST_ADDR;
                    end
                end

                ST_ADDR: begin
                    if (!bit_ok) begin
                        cnt_q    <= '0;
                        sready_q <= 1'b1;
                        state_q  <= ST_IDLE;
                    end else begin
                        addr_q <= addr_d;
                        if (addr_last) begin
                            cnt_q <= '0;
                            lat_q <= '0;
                            if (mode_q == MODE_WRITE) begin
                                state_q <= ST_WDATA;
                            end else begin
                                ssplit_q <= 1'b1;
                                state_q  <= ST_SPLIT;
                            end
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end

                ST_WDATA: begin
                    if (!bit_ok) begin
                        cnt_q    <= '0;
                        sready_q <= 1'b1;
                        state_q  <= ST_IDLE;
                    end else begin
                        data_q <= data_d;
                        if (data_last) begin
                            cnt_q   <= '0;
                            state_q <= ST_WRITE;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end

                ST_WRITE: begin
                    cnt_q    <= '0;
                    sready_q <= 1'b1;
                    state_q  <= ST_IDLE;
                end

                ST_SPLIT: begin
                    if (lat_done) begin
                        rword_q  <= mem_rdata;
                        lat_q    <= '0;
                        cnt_q    <= '0;
                        ssplit_q <= 1'b0;
                        state_q  <= ST_GRANT_WAIT;
                    end else begin
                        lat_q <= lat_q + 4'd1;
                    end
                end

                ST_GRANT_WAIT: begin
                    if (bus.split_grant) begin
                        srvalid_q <= 1'b1;
                        srdata_q  <= rword_q[0];
                        rword_q   <= rword_q >> 1;
                        cnt_q     <= '0;
                        state_q   <= ST_RDATA;
                    end
                end

                ST_RDATA: begin
                    if (data_last) begin
                        srvalid_q <= 1'b0;
                        srdata_q  <= 1'b0;
                        sready_q  <= 1'b1;
                        cnt_q     <= '0;
                        state_q   <= ST_IDLE;
                    end else begin
                        srdata_q <= rword_q[0];
                        rword_q  <= rword_q >> 1;
                        cnt_q    <= cnt_q + 1'b1;
                    end
                end

                default: begin
                    cnt_q     <= '0;
                    lat_q     <= '0;
                    sready_q  <= 1'b1;
                    ssplit_q  <= 1'b0;
                    srvalid_q <= 1'b0;
                    srdata_q  <= 1'b0;
                    state_q   <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.sready  = sready_q;
    assign bus.ssplit  = ssplit_q;
    assign bus.srvalid = srvalid_q;
    assign bus.srdata  = srdata_q;

endmodule

// File: tb/tb_split_slave_port.sv
// tb/tb_split_slave_port.sv - self-checking bench for split_slave_port
module tb_split_slave_port;
    import split_bus_pkg::*;

    localparam int AW    = 12;
    localparam int DW    = 8;
    localparam int DEPTH = 2048;
    localparam int LAT   = 4;

    logic clk  = 1'b0;
    logic rstn = 1'b0;

    split_slave_port_if bus_if();

    split_slave_port #(
        .ADDR_WIDTH   (AW),
        .DATA_WIDTH   (DW),
        .MEM_DEPTH    (DEPTH),
        .READ_LATENCY (LAT)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus_if)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Expected output levels after the most recent rising edge.
    logic exp_sready  = 1'b1;
    logic exp_ssplit  = 1'b0;
    logic exp_srvalid = 1'b0;
    logic exp_srdata  = 1'b0;
    bit   cmp_en      = 1'b0;

    int          ssplit_cycles = 0;
    int          rx_n          = 0;
    logic [31:0] rx_word       = '0;

    logic [DW-1:0] mem_m [int];
    int            keys[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("sready",  32'(bus_if.sready),  32'(exp_sready));
            chk("ssplit",  32'(bus_if.ssplit),  32'(exp_ssplit));
            chk("srvalid", 32'(bus_if.srvalid), 32'(exp_srvalid));
            chk("srdata",  32'(bus_if.srdata),  32'(exp_srdata));
            if (bus_if.ssplit === 1'b1) ssplit_cycles++;
            if (bus_if.srvalid === 1'b1) begin
                if (rx_n < 32) rx_word[rx_n] = bus_if.srdata;
                rx_n++;
            end
        end
    end

    task tick;
        @(posedge clk);
        #1;
    endtask

    task drive_idle;
        bus_if.ssel        = 1'b0;
        bus_if.mvalid      = 1'b0;
        bus_if.mmode       = 1'b0;
        bus_if.mwdata      = 1'b0;
        bus_if.split_grant = 1'b0;
    endtask

    task send_bit(input logic b, input logic mode);
        bus_if.ssel   = 1'b1;
        bus_if.mvalid = 1'b1;
        bus_if.mwdata = b;
        bus_if.mmode  = mode;
        tick;
        exp_sready = 1'b0;
    endtask

    // abort_n > 0: drop the request before serial bit abort_n (drop_sel 0 = mvalid, 1 = ssel).
    task automatic write_txn(input logic [AW-1:0] a, input logic [DW-1:0] d,
                             input int abort_n, input int drop_sel);
        logic [AW+DW-1:0] bits;
        int               key;
        bits = {d, a};
        for (int i = 0; i < AW + DW; i++) begin
            if (abort_n > 0 && i == abort_n) begin
                bus_if.mwdata = logic'($urandom_range(0, 1));
                if (drop_sel == 0) bus_if.mvalid = 1'b0;
                else               bus_if.ssel   = 1'b0;
                tick;
                exp_sready = 1'b1;
                drive_idle;
                return;
            end
            send_bit(bits[i], (i == 0) ? MODE_WRITE : logic'($urandom_range(0, 1)));
        end
        drive_idle;
        tick;
        exp_sready = 1'b1;
        key = int'(a) % DEPTH;
        if (!mem_m.exists(key)) keys.push_back(key);
        mem_m[key] = d;
    endtask

    // stray_c: SPLIT cycle index (0..LAT-1) in which a split_grant pulse is injected, -1 none.
    task automatic read_txn(input logic [AW-1:0] a, input int gwait, input int stray_c,
                            input bit reset_mid, output logic [DW-1:0] got);
        logic [DW-1:0] e;
        e = mem_m[int'(a) % DEPTH];
        got = '0;
        rx_n = 0;
        rx_word = '0;
        ssplit_cycles = 0;
        for (int i = 0; i < AW; i++) begin
            send_bit(a[i], (i == 0) ? MODE_READ : logic'($urandom_range(0, 1)));
        end
        drive_idle;
        exp_ssplit = 1'b1;
        if (reset_mid) begin
            tick;
            rstn = 1'b0;
            #1;
            chk("reset_mid_ssplit", 32'(bus_if.ssplit), 32'd0);
            chk("reset_mid_sready", 32'(bus_if.sready), 32'd1);
            exp_ssplit = 1'b0;
            exp_sready = 1'b1;
            tick;
            rstn = 1'b1;
            bus_if.split_grant = 1'b1;
            tick;
            bus_if.split_grant = 1'b0;
            repeat (12) tick;
            chk("no_srvalid_after_reset", 32'(rx_n), 32'd0);
            return;
        end
        for (int c = 0; c < LAT; c++) begin
            if (c == stray_c) bus_if.split_grant = 1'b1;
            tick;
            bus_if.split_grant = 1'b0;
            if (c == LAT - 1) exp_ssplit = 1'b0;
        end
        repeat (gwait) tick;
        bus_if.split_grant = 1'b1;
        tick;
        bus_if.split_grant = 1'b0;
        exp_srvalid = 1'b1;
        exp_srdata  = e[0];
        for (int i = 1; i <= DW; i++) begin
            bus_if.ssel   = logic'($urandom_range(0, 1));
            bus_if.mvalid = logic'($urandom_range(0, 1));
            bus_if.mwdata = logic'($urandom_range(0, 1));
            tick;
            if (i < DW) begin
                exp_srdata = e[i];
            end else begin
                exp_srvalid = 1'b0;
                exp_srdata  = 1'b0;
                exp_sready  = 1'b1;
            end
        end
        drive_idle;
        got = rx_word[DW-1:0];
    endtask

    task idle_noise(input int n);
        for (int i = 0; i < n; i++) begin
            case ($urandom_range(0, 2))
                0:       begin bus_if.ssel = 1'b1; bus_if.mvalid = 1'b0; end
                1:       begin bus_if.ssel = 1'b0; bus_if.mvalid = 1'b1; end
                default: bus_if.split_grant = 1'b1;
            endcase
            bus_if.mwdata = logic'($urandom_range(0, 1));
            tick;
            drive_idle;
        end
    endtask

    initial begin
        logic [DW-1:0] got;
        logic [AW-1:0] a;
        int            k;

        drive_idle;
        rstn   = 1'b0;
        cmp_en = 1'b1;
        repeat (3) tick;
        rstn = 1'b1;
        tick;
        chk("reset_sready",  32'(bus_if.sready),  32'd1);
        chk("reset_ssplit",  32'(bus_if.ssplit),  32'd0);
        chk("reset_srvalid", 32'(bus_if.srvalid), 32'd0);

        // Write 0xA5 to 0x005; no split must appear.
        ssplit_cycles = 0;
        write_txn(12'h005, 8'hA5, 0, 0);
        tick;
        chk("write_no_ssplit", 32'(ssplit_cycles), 32'd0);

        // Read back with grant after 10 GRANT_WAIT cycles.
        read_txn(12'h005, 10, -1, 1'b0, got);
        chk("read_ssplit_cycles", 32'(ssplit_cycles), 32'd4);
        chk("read_bit_count",     32'(rx_n),          32'd8);
        chk("read_word_a5",       32'(got),           32'h0000_00A5);

        // Grants in IDLE and in SPLIT are ignored.
        bus_if.split_grant = 1'b1;
        tick;
        bus_if.split_grant = 1'b0;
        tick;
        read_txn(12'h005, 5, 1, 1'b0, got);
        chk("stray_grant_word", 32'(got),  32'h0000_00A5);
        chk("stray_grant_bits", 32'(rx_n), 32'd8);

        // 0xFFF aliases to word 0x7FF.
        write_txn(12'hFFF, 8'h3C, 0, 0);
        read_txn(12'h7FF, 2, -1, 1'b0, got);
        chk("alias_fff_to_7ff", 32'(got), 32'h0000_003C);

        // Aborted write (mvalid dropped after 6 address bits) leaves memory unchanged.
        write_txn(12'h7FF, 8'hC3, 6, 0);
        tick;
        chk("abort_sready", 32'(bus_if.sready), 32'd1);
        read_txn(12'h7FF, 0, -1, 1'b0, got);
        chk("abort_keeps_old", 32'(got), 32'h0000_003C);

        // Reset in the middle of a split read.
        read_txn(12'h005, 0, -1, 1'b1, got);

        // Randomized traffic against the model.
        for (int t = 0; t < 40; t++) begin
            idle_noise($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 0 || keys.size() == 0) begin
                a = AW'($urandom_range(0, 4095));
                if ($urandom_range(0, 4) == 0)
                    write_txn(a, DW'($urandom), $urandom_range(1, AW + DW - 1), $urandom_range(0, 1));
                else
                    write_txn(a, DW'($urandom), 0, 0);
            end else begin
                k = keys[$urandom_range(0, keys.size() - 1)];
                a = AW'(k + DEPTH * int'($urandom_range(0, 1)));
                read_txn(a, $urandom_range(0, 12),
                         ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, LAT - 1)) : -1,
                         1'b0, got);
                chk("rand_read_bits", 32'(rx_n), 32'(DW));
                chk("rand_read_word", 32'(got), 32'(mem_m[k]));
            end
        end
        repeat (3) tick;
        cmp_en = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
